// File: rtl/rs_enc_6p.sv
// ---------------------------------------------------------------------------
// rs_enc_6p -- systematic Reed-Solomon encoder, RS(MSG_LEN+6, MSG_LEN), GF(2^8)
//
// Field polynomial x^8+x^4+x^3+x^2+1 (0x11D). Generator
//   g(x) = x^6 + 126x^5 + 4x^4 + 158x^3 + 28x^2 + 49x + 117
//
// Message symbols pass straight through (zero latency) while a 6-stage LFSR
// accumulates the remainder. Once the message ends, the 6 parity symbols are
// shifted out highest-order first.
//
// Optional feature (macro RS_ENC_SHORTEN_EN): when defined, din_last on an
// accepted message symbol ends the message early (shortened code). When it
// is undefined, din_last is ignored and each message is exactly MSG_LEN long.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   din_valid   in   message symbol valid
//   din_ready   out  din accepted this cycle (mirrors dout_ready in DATA)
//   din[7:0]    in   message symbol
//   din_last    in   last message symbol (RS_ENC_SHORTEN_EN only)
//   dout_valid  out  output symbol valid
//   dout_ready  in   downstream accepts dout
//   dout[7:0]   out  codeword symbol
//   dout_par    out  dout is a parity symbol
//   dout_last   out  dout is the final symbol of the codeword
// ---------------------------------------------------------------------------

// Constant multiplier in GF(2^8)/0x11D: XOR of the input times x^i for every
// set bit i of COEF. Folds to a small XOR network per output bit.
module gf_mul_const #(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (COEF[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
  end

  assign y = acc;
endmodule

module rs_enc_6p #(
  parameter int unsigned MSG_LEN = 249
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] din,
  input  logic       din_last,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       dout_par,
  output logic       dout_last
);
  localparam int          NPAR     = 6;
  localparam logic [7:0]  LAST_IDX = 8'(MSG_LEN - 1);
  localparam logic [7:0]  PAR_LAST = 8'(NPAR - 1);
  // Generator coefficients, index k = g_k (g6 = 1 is implicit)
  localparam logic [NPAR-1:0][7:0] GEN = {8'd126, 8'd4, 8'd158, 8'd28, 8'd49, 8'd117};

  typedef enum logic {ST_DATA, ST_PAR} state_e;

  state_e                  state_q, state_d;
  logic [NPAR-1:0][7:0]    p_q, p_d;     // p_q[5] is the highest-order parity
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              fb;
  logic [NPAR-1:0][7:0]    gfb;          // g_k * fb
  logic                    msg_end;

  assign fb = din ^ p_q[NPAR-1];

  for (genvar k = 0; k < NPAR; k++) begin : g_tap
    gf_mul_const #(.COEF(GEN[k])) u_mul (
      .a (fb),
      .y (gfb[k])
    );
  end

`ifdef RS_ENC_SHORTEN_EN
  // din_last and the length limit landing together still give one PAR entry
  assign msg_end = (cnt_q == LAST_IDX) || din_last;
`else
  logic unused_din_last;
  assign unused_din_last = din_last;
  assign msg_end = (cnt_q == LAST_IDX);
`endif

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = din;
    dout_par   = 1'b0;
    dout_last  = 1'b0;

    unique case (state_q)
      ST_DATA: begin
        dout_valid = din_valid;
        din_ready  = dout_ready;
        if (din_valid && dout_ready) begin
          for (int k = 1; k < NPAR; k++) p_d[k] = p_q[k-1] ^ gfb[k];
          p_d[0] = gfb[0];
          cnt_d  = cnt_q + 8'd1;
          if (msg_end) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end
        end
      end

      ST_PAR: begin
        dout_valid = 1'b1;
        dout       = p_q[NPAR-1];
        dout_par   = 1'b1;
        dout_last  = (cnt_q == PAR_LAST);
        if (dout_ready) begin
          p_d   = {p_q[NPAR-2:0], 8'h00};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == PAR_LAST) begin
            // Shift has already zeroed p; clear explicitly for clarity
            state_d = ST_DATA;
            p_d     = '0;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rs_enc_6p.sv
// ---------------------------------------------------------------------------
// tb_rs_enc_6p -- self-checking bench for rs_enc_6p (MSG_LEN = 249).
// Directed table of known parity vectors, reset/abort sequences, and random
// codewords checked against a polynomial long-division reference.
// ---------------------------------------------------------------------------
module tb_rs_enc_6p;
  localparam int MSG_LEN = 249;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] din;
  logic       din_last;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout;
  logic       dout_par;
  logic       dout_last;

  always #5 clk = ~clk;

  rs_enc_6p #(.MSG_LEN(MSG_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .din_last   (din_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_par   (dout_par),
    .dout_last  (dout_last)
  );

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0]  last_sym;
    int          rnd;       // 1: random dout_ready and din_valid gaps
    logic [47:0] par;       // first emitted parity in [47:40]
  } dvec_t;

  exp_t       exp_q [$];
  logic [7:0] msg [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         idle_cnt = 0;
  int         rdy_mode = 0;  // 0: ready low, 1: ready high, 2: random
  logic       mon_en = 1'b0;
  logic       gap_chk = 1'b0;
  logic       hold_prev = 1'b0;
  logic [9:0] prev_out;
  string      tname = "init";

  // ---------------- reference model: m(x)*x^6 mod g(x) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [47:0] ref_parity(input logic [7:0] m [$]);
    logic [7:0] gen [7];
    logic [7:0] r [$];
    logic [7:0] q;
    logic [47:0] par = '0;
    int L = m.size();
    gen = '{8'd1, 8'd126, 8'd4, 8'd158, 8'd28, 8'd49, 8'd117};
    r = m;
    for (int i = 0; i < 6; i++) r.push_back(8'h00);
    for (int i = 0; i < L; i++) begin
      q = r[i];
      for (int j = 1; j <= 6; j++) r[i+j] = r[i+j] ^ gmul(q, gen[j]);
    end
    for (int k = 0; k < 6; k++) par = {par[39:0], r[L+k]};
    return par;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic push_cw(input logic [7:0] m [$], input logic [47:0] par);
    for (int i = 0; i < m.size(); i++) exp_q.push_back('{m[i], 1'b0, 1'b0});
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{par[47-8*k -: 8], 1'b1, (k == 5)});
  endtask

  task automatic drive_cw(input logic [7:0] m [$], input bit rnd, input bit use_last);
    bit acc;
    int guard;
    for (int i = 0; i < m.size(); i++) begin
      if (rnd)
        while ($urandom_range(0, 3) == 0) begin
          din_valid = 1'b0; din = 8'($urandom); din_last = 1'b0;
          @(posedge clk); #1;
        end
      din       = m[i];
      din_last  = use_last && (i == m.size() - 1);
      din_valid = 1'b1;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 400) begin
        @(negedge clk); acc = din_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("din_accept_timeout", 32'(acc), 32'd1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 4000) begin
      @(posedge clk); g++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    gap_chk = 1'b0;
    #1;
  endtask

  function automatic void fill_msg(input int n, input logic [7:0] last_sym, input bit rnd_data);
    msg.delete();
    for (int i = 0; i < n - 1; i++) msg.push_back(rnd_data ? 8'($urandom) : 8'h00);
    msg.push_back(last_sym);
  endfunction

  task automatic abort_run(input int n);
    mon_en = 1'b0;
    rdy_mode = 1;
    fill_msg(n, 8'($urandom_range(1, 255)), 1'b1);
    drive_cw(msg, 1'b0, 1'b0);
    din_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_par", 32'(dout_par), 32'(n == MSG_LEN));
    rst_n = 1'b0; #1;
    chk("abort_rst_par", 32'(dout_par), 32'd0);
    chk("abort_rst_last", 32'(dout_last), 32'd0);
    chk("abort_rst_valid", 32'(dout_valid), 32'(din_valid));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // ---------------- dout_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", 32'({dout, dout_par, dout_last}), 32'(prev_out));
      if (dout_par) chk("par_din_ready", 32'(din_ready), 32'd0);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got %0h, want no output", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(tname, 32'({dout, dout_par, dout_last}), 32'({e.d, e.par, e.last}));
        end
      end
      if (gap_chk && !dout_valid) idle_cnt++;
      hold_prev = dout_valid && !dout_ready;
      prev_out  = {dout, dout_par, dout_last};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    dvec_t tbl [4];
    logic [47:0] p;
    tbl[0] = '{8'h00, 0, 48'h000000000000};
    tbl[1] = '{8'h01, 0, 48'h7E049E1C3175};
    tbl[2] = '{8'h02, 0, 48'hFC08213862EA};
    tbl[3] = '{8'h01, 1, 48'h7E049E1C3175};

    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_par", 32'(dout_par), 32'd0);
    chk("rst_dout_last", 32'(dout_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Pass-through after reset: dout follows din, nothing accepted with ready low
    din_valid = 1'b1; din = 8'hA5; #1;
    chk("post_rst_valid", 32'(dout_valid), 32'd1);
    chk("post_rst_dout", 32'(dout), 32'hA5);
    chk("post_rst_din_ready", 32'(din_ready), 32'd0);
    chk("post_rst_par", 32'(dout_par), 32'd0);
    din_valid = 1'b0; #1;
    chk("post_rst_valid_lo", 32'(dout_valid), 32'd0);
    rdy_mode = 1;
    @(posedge clk); #2;
    chk("post_rst_ready_follow", 32'(din_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table (back-to-back codewords)
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tname = $sformatf("dir%0d", i);
      rdy_mode = tbl[i].rnd ? 2 : 1;
      fill_msg(MSG_LEN, tbl[i].last_sym, 1'b0);
      push_cw(msg, tbl[i].par);
      drive_cw(msg, tbl[i].rnd != 0, 1'b1);
    end
    din_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset mid-message and mid-parity, then a clean codeword
    abort_run(100);
    abort_run(MSG_LEN);
    tname = "after_abort";
    fill_msg(MSG_LEN, 8'h01, 1'b0);
    push_cw(msg, tbl[1].par);
    drive_cw(msg, 1'b0, 1'b1);
    din_valid = 1'b0;
    drain();

    // Random codewords against the reference model
    for (int k = 0; k < 6; k++) begin
      int len;
      tname = $sformatf("rnd%0d", k);
      rdy_mode = (k % 2 == 0) ? 2 : 1;
`ifdef RS_ENC_SHORTEN_EN
      len = $urandom_range(1, MSG_LEN);
`else
      len = MSG_LEN;
`endif
      fill_msg(len, 8'($urandom), 1'b1);
      p = ref_parity(msg);
      push_cw(msg, p);
      drive_cw(msg, k % 2 == 0, 1'b1);
    end
    din_valid = 1'b0;
    rdy_mode = 1;
    drain();

`ifdef RS_ENC_SHORTEN_EN
    // Single-symbol shortened codeword, then back-to-back with no idle cycle
    tname = "short1";
    rdy_mode = 1;
    idle_cnt = 0;
    gap_chk = 1'b1;
    msg.delete(); msg.push_back(8'h01);
    push_cw(msg, tbl[1].par);
    drive_cw(msg, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tname = $sformatf("short_b2b%0d", k);
      fill_msg($urandom_range(1, 20), 8'($urandom), 1'b1);
      p = ref_parity(msg);
      push_cw(msg, p);
      drive_cw(msg, 1'b0, 1'b1);
    end
    din_valid = 1'b0;
    drain();
    chk("short_idle_cycles", 32'(idle_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_enc_6p.md
RS_ENC_6P -- requirements
Module: rs_enc_6p

Interface
REQ-001 Parameter MSG_LEN, default 249, meaning message symbols per codeword (legal range 1..249), giving RS(MSG_LEN+6, MSG_LEN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 din_valid  input  1  message symbol valid.
REQ-005 din_ready  output  1  block accepts din this cycle.
REQ-006 din  input  8  message symbol, GF(2^8).
REQ-007 din_last  input  1  final message symbol of the codeword (used only under REQ-026).
REQ-008 dout_valid  output  1  output symbol valid.
REQ-009 dout_ready  input  1  downstream accepts dout.
REQ-010 dout  output  8  codeword symbol.
REQ-011 dout_par  output  1  current dout is a parity symbol.
REQ-012 dout_last  output  1  current dout is the last symbol of the codeword.

Function
REQ-013 Field GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D); generator g(x)=x^6+126x^5+4x^4+158x^3+28x^2+49x+117, with g5..g0 implemented as the team's constant GF multipliers.
REQ-014 The encoder is systematic: message symbols pass to dout unchanged, then 6 parity symbols follow, highest-order first.
REQ-015 States: DATA and PAR; reset state is DATA.
REQ-016 In DATA: dout=din, dout_valid=din_valid, din_ready=dout_ready, dout_par=0, dout_last=0 (combinational pass-through, zero latency).
REQ-017 Transfer in DATA means din_valid&&dout_ready; on transfer fb=din^p5, p5<=p4^g5*fb, p4<=p3^g4*fb, p3<=p2^g3*fb, p2<=p1^g2*fb, p1<=p0^g1*fb, p0<=g0*fb, and the 8-bit symbol counter increments.
REQ-018 No transfer: parity registers and counter hold.
REQ-019 Transfer of symbol number MSG_LEN (counter==MSG_LEN-1) moves the block to PAR and clears the counter.
REQ-020 In PAR: din_ready=0, dout_valid=1, dout=p5, dout_par=1; dout_last=1 on the 6th parity symbol.
REQ-021 On dout_ready in PAR, parity shifts (p5<=p4 ... p1<=p0, p0<=0) and the counter increments; hold otherwise, with dout stable.
REQ-022 Acceptance of the 6th parity symbol returns the block to DATA with all p registers equal to 0 and the counter equal to 0; the next codeword may start in the following cycle.
REQ-023 A din_valid in PAR is ignored; upstream holds it under the handshake.

Reset
REQ-024 rst_n low asynchronously forces DATA, p0..p5=0 and counter=0; dout_valid then follows din_valid and dout_par=dout_last=0.
REQ-025 Reset asserted mid-codeword discards the partial codeword; no parity is emitted for it.

Configuration
REQ-026 Macro RS_ENC_SHORTEN_EN: when defined, a DATA transfer with din_last=1 ends the message early (shortened code) and enters PAR exactly as in REQ-019; when undefined, din_last is ignored and every codeword has exactly MSG_LEN message symbols.
REQ-027 Under RS_ENC_SHORTEN_EN, din_last coinciding with counter==MSG_LEN-1 produces one PAR entry only.

Verification
REQ-028 MSG_LEN zeros streamed with dout_ready=1 -> MSG_LEN zeros passed through, then parity 0,0,0,0,0,0 with dout_last only on the 6th.
REQ-029 MSG_LEN-1 zeros, then 0x01 -> parity 0x7E,0x04,0x9E,0x1C,0x31,0x75.
REQ-030 MSG_LEN-1 zeros, then 0x02 -> parity 0xFC,0x08,0x21,0x38,0x62,0xEA.
REQ-031 REQ-029 stimulus with dout_ready toggled randomly -> identical symbol sequence; dout stable while dout_valid&&!dout_ready; din_ready=0 throughout PAR.
REQ-032 rst_n pulsed low after 100 symbols, then REQ-029 stimulus -> REQ-029 parity, with no residue from the aborted codeword.
REQ-033 RS_ENC_SHORTEN_EN defined: single symbol 0x01 with din_last=1 -> parity 0x7E,0x04,0x9E,0x1C,0x31,0x75, then back-to-back codewords with no idle cycle.
